// File: rtl/shifter_arbiter.sv
// shifter_arbiter
//   Shares one Right_Barrel_Shifter between two requesters. A request is
//   latched into op_data/op_ctrl. The shifter output is then registered into
//   rsp_data and returned to the port that issued the request. When both ports
//   request at once, the port that was not granted last time wins.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-port request handshake (ready is combinational)
//   req_data0/1            per-port operand
//   req_ctrl0/1            per-port shift amount
//   rsp_valid/rsp_ready    per-port response handshake
//   rsp_data               result, meaningful on the port with rsp_valid set
//   busy                   high whenever the sequencer is not idle
//
// Right_Barrel_Shifter
//   Logical right shift of a 16-bit operand by 0..15 positions, zero fill.
//   Built as four mux stages that shift by 1, 2, 4 and 8.

module Right_Barrel_Shifter (
  input  logic [15:0] data,
  input  logic [3:0]  control,
  output logic [15:0] result
);

  logic [15:0] s0, s1, s2;

  assign s0     = control[0] ? {1'b0,  data[15:1]} : data;
  assign s1     = control[1] ? {2'b0,  s0[15:2]}   : s0;
  assign s2     = control[2] ? {4'b0,  s1[15:4]}   : s1;
  assign result = control[3] ? {8'b0,  s2[15:8]}   : s2;

endmodule

// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbitrating; req_ready offered to the winner
// SHIFT | shifter settling on op_data/op_ctrl; result captured on edge
// RESP  | rsp_valid[gnt] held with stable rsp_data until rsp_ready[gnt]
module shifter_arbiter #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   op_data;
  logic [CTRL_W-1:0]   op_ctrl;
  logic                gnt;
  logic                last_grant;
  logic                win;
  logic [DATA_W-1:0]   result;

  Right_Barrel_Shifter u_shifter (
    .data    (op_data),
    .control (op_ctrl),
    .result  (result)
  );

  // On a tie the port that did not win last time gets the slot, so a port
  // that keeps re-requesting can never lock the other one out.
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
  end

  assign req_ready = (state == IDLE && req_valid[win]) ? (win ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_data    <= '0;
      op_ctrl    <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            op_data    <= win ? req_data1 : req_data0;
            op_ctrl    <= win ? req_ctrl1 : req_ctrl0;
            gnt        <= win;
            last_grant <= win;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_data  <= result;
          rsp_valid <= gnt ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          // rsp_ready of the other port is deliberately ignored.
          if (rsp_ready[gnt]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
